// File: rtl/rgb_sram_writer_pkg.sv
// Shared definitions for the RGB frame writer and its neighbours on the
// SRAM/VGA path.
//   rgb_writer_state_type : FSM states of rgb_sram_writer
//   RGB_BASE_ADDRESS      : default frame location, shared with the display fetch
//   *_W                   : common bus widths
package rgb_sram_writer_pkg;

   localparam int SRAM_ADDR_W = 18;
   localparam int SRAM_DATA_W = 16;
   localparam int PIXEL_W     = 24;
   localparam int OFFSET_W    = 17;

   localparam logic [SRAM_ADDR_W-1:0] RGB_BASE_ADDRESS = 18'd146944;

   typedef enum logic [2:0] {
      S_RW_IDLE,
      S_RW_WAIT_EVEN,
      S_RW_WAIT_ODD,
      S_RW_WR_0,
      S_RW_WR_1,
      S_RW_WR_2,
      S_RW_DONE
   } rgb_writer_state_type;

endpackage

// File: rtl/rgb_sram_writer_packer.sv
// rgb_pair_packer: packs an even/odd pixel pair into three 16-bit SRAM words,
// matching the layout the VGA display fetch unpacks.
//   p0_i  : even pixel {R0,G0,B0}
//   p1_i  : odd pixel  {R1,G1,B1}
//   w0_o  : {R0,G0}
//   w1_o  : {B0,R1}
//   w2_o  : {G1,B1}
module rgb_pair_packer
   import rgb_sram_writer_pkg::*;
(
   input  logic [PIXEL_W-1:0]     p0_i,
   input  logic [PIXEL_W-1:0]     p1_i,
   output logic [SRAM_DATA_W-1:0] w0_o,
   output logic [SRAM_DATA_W-1:0] w1_o,
   output logic [SRAM_DATA_W-1:0] w2_o
);

   assign w0_o = p0_i[23:8];
   assign w1_o = {p0_i[7:0], p1_i[23:16]};
   assign w2_o = p1_i[15:0];

endmodule

// File: rtl/rgb_sram_writer.sv
// rgb_sram_writer: accepts a valid/ready stream of 24-bit RGB pixels and writes
// one frame into SRAM, three 16-bit words per pixel pair, starting at a base
// address sampled on start.
//   Clock, Reset          : system clock, synchronous active-high reset
//   start                 : one-cycle pulse, begins a frame when idle
//   SRAM_base_address     : word address of pixel 0
//   pixel_valid/ready     : pixel handshake; pixel_R/G/B carry the pixel
//   SRAM_address/write_data/we_n : registered SRAM write port
//   busy                  : frame in progress
//   done                  : one-cycle pulse after the last word is written
module rgb_sram_writer
   import rgb_sram_writer_pkg::*;
#(
   parameter int FRAME_WIDTH  = 320,
   parameter int FRAME_HEIGHT = 240
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic                   start,
   input  logic [SRAM_ADDR_W-1:0] SRAM_base_address,
   input  logic                   pixel_valid,
   output logic                   pixel_ready,
   input  logic [7:0]             pixel_R,
   input  logic [7:0]             pixel_G,
   input  logic [7:0]             pixel_B,
   output logic [SRAM_ADDR_W-1:0] SRAM_address,
   output logic [SRAM_DATA_W-1:0] SRAM_write_data,
   output logic                   SRAM_we_n,
   output logic                   busy,
   output logic                   done
);

   localparam int NUM_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
   localparam int NUM_PAIRS  = NUM_PIXELS / 2;
   localparam int PAIR_W     = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
   localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_PAIRS - 1);

   rgb_writer_state_type   state_q, state_d;
   logic [SRAM_ADDR_W-1:0] base_q, base_d;
   logic [OFFSET_W-1:0]    offset_q, offset_d;
   logic [PAIR_W-1:0]      pair_q, pair_d;
   logic [PIXEL_W-1:0]     p0_q, p0_d;
   logic [PIXEL_W-1:0]     p1_q, p1_d;
   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [SRAM_DATA_W-1:0] data_q, data_d;
   logic                   we_n_q, we_n_d;

   logic [PIXEL_W-1:0]     pixel_in;
   logic [SRAM_DATA_W-1:0] w0, w1, w2;

   assign pixel_in = {pixel_R, pixel_G, pixel_B};

   // w0 depends only on p0, which is already latched while waiting for p1,
   // so the first word can be registered on the same edge that accepts p1.
   rgb_pair_packer u_packer (
      .p0_i (p0_q),
      .p1_i (p1_q),
      .w0_o (w0),
      .w1_o (w1),
      .w2_o (w2)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= S_RW_IDLE;
         offset_q <= '0;
         pair_q   <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         we_n_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
         pair_q   <= pair_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         we_n_q   <= we_n_d;
      end
   end

   always_ff @(posedge Clock) begin
      base_q <= base_d;
      p0_q   <= p0_d;
      p1_q   <= p1_d;
   end

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      offset_d = offset_q;
      pair_d   = pair_q;
      p0_d     = p0_q;
      p1_d     = p1_q;
      addr_d   = addr_q;
      data_d   = data_q;
      we_n_d   = 1'b1;

      case (state_q)
         S_RW_IDLE: begin
            if (start) begin
               base_d   = SRAM_base_address;
               offset_d = '0;
               pair_d   = '0;
               state_d  = S_RW_WAIT_EVEN;
            end
         end
         // pixel_ready is high in both wait states, so accept == pixel_valid
         S_RW_WAIT_EVEN: begin
            if (pixel_valid) begin
               p0_d    = pixel_in;
               state_d = S_RW_WAIT_ODD;
            end
         end
         S_RW_WAIT_ODD: begin
            if (pixel_valid) begin
               p1_d    = pixel_in;
               addr_d  = base_q + {1'b0, offset_q};
               data_d  = w0;
               we_n_d  = 1'b0;
               state_d = S_RW_WR_0;
            end
         end
         S_RW_WR_0: begin
            addr_d  = addr_q + 18'd1;
            data_d  = w1;
            we_n_d  = 1'b0;
            state_d = S_RW_WR_1;
         end
         S_RW_WR_1: begin
            addr_d  = addr_q + 18'd1;
            data_d  = w2;
            we_n_d  = 1'b0;
            state_d = S_RW_WR_2;
         end
         S_RW_WR_2: begin
            offset_d = offset_q + 17'd3;
            if (pair_q == LAST_PAIR) begin
               state_d = S_RW_DONE;
            end else begin
               pair_d  = pair_q + PAIR_W'(1);
               state_d = S_RW_WAIT_EVEN;
            end
         end
         S_RW_DONE: begin
            state_d = S_RW_IDLE;
         end
         default: begin
            state_d = S_RW_IDLE;
         end
      endcase
   end

   assign pixel_ready     = (state_q == S_RW_WAIT_EVEN) || (state_q == S_RW_WAIT_ODD);
   assign busy            = (state_q != S_RW_IDLE) && (state_q != S_RW_DONE);
   assign done            = (state_q == S_RW_DONE);
   assign SRAM_address    = addr_q;
   assign SRAM_write_data = data_q;
   assign SRAM_we_n       = we_n_q;

endmodule

// File: tb/tb_rgb_sram_writer.sv
// Self-checking bench for rgb_sram_writer on a reduced 8x4 frame: random pixels
// and random valid gaps, every SRAM write captured and compared against a
// pixel-level model of the frame layout.
module tb_rgb_sram_writer;
   import rgb_sram_writer_pkg::*;

   localparam int FW     = 8;
   localparam int FH     = 4;
   localparam int NPAIR  = FW * FH / 2;
   localparam int NWORD  = NPAIR * 3;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        start;
   logic [17:0] SRAM_base_address;
   logic        pixel_valid;
   logic        pixel_ready;
   logic [7:0]  pixel_R, pixel_G, pixel_B;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int frames_exp = 0;
   logic prev_done = 1'b0;

   logic [33:0] got_q[$];
   logic [33:0] exp_q[$];

   rgb_sram_writer #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)) dut (
      .Clock             (Clock),
      .Reset             (Reset),
      .start             (start),
      .SRAM_base_address (SRAM_base_address),
      .pixel_valid       (pixel_valid),
      .pixel_ready       (pixel_ready),
      .pixel_R           (pixel_R),
      .pixel_G           (pixel_G),
      .pixel_B           (pixel_B),
      .SRAM_address      (SRAM_address),
      .SRAM_write_data   (SRAM_write_data),
      .SRAM_we_n         (SRAM_we_n),
      .busy              (busy),
      .done              (done)
   );

   always #10 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [33:0] got, input logic [33:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // write capture plus per-cycle protocol checks
   always @(negedge Clock) begin
      if (SRAM_we_n === 1'b0) begin
         got_q.push_back({SRAM_address, SRAM_write_data});
         check_val("ready_low_while_writing", pixel_ready, 0);
      end
      if (done === 1'b1) begin
         done_cnt++;
         check_val("busy_low_with_done", busy, 0);
         check_val("done_single_pulse", prev_done, 0);
      end
      prev_done <= done;
   end

   // frame layout model: pair k occupies base+3k..base+3k+2 modulo 2^18
   function automatic void model_pair(input logic [17:0] base, input int k,
                                      input logic [23:0] p0, input logic [23:0] p1);
      int unsigned r0, g0, b0, r1, g1, b1, a;
      r0 = p0 / 65536; g0 = (p0 / 256) % 256; b0 = p0 % 256;
      r1 = p1 / 65536; g1 = (p1 / 256) % 256; b1 = p1 % 256;
      a  = int'(base) + 3 * k;
      exp_q.push_back({18'(a % 262144),       16'(r0 * 256 + g0)});
      exp_q.push_back({18'((a + 1) % 262144), 16'(b0 * 256 + r1)});
      exp_q.push_back({18'((a + 2) % 262144), 16'(g1 * 256 + b1)});
   endfunction

   task automatic start_frame(input logic [17:0] b, output int c_s);
      @(posedge Clock); #1;
      start = 1'b1;
      SRAM_base_address = b;
      c_s = cyc;
      @(posedge Clock); #1;
      start = 1'b0;
      SRAM_base_address = 18'($urandom);
      check_val("busy_after_start", busy, 1);
   endtask

   // called at posedge+1; returns at posedge+1 of the cycle after acceptance
   task automatic send_pixel(input logic [23:0] px, input int pct);
      bit sent = 0;
      int guard = 0;
      while (!sent) begin
         if ($urandom_range(99) < pct) begin
            pixel_valid = 1'b1;
            {pixel_R, pixel_G, pixel_B} = px;
         end else begin
            pixel_valid = 1'b0;
            {pixel_R, pixel_G, pixel_B} = 24'($urandom);
         end
         sent = pixel_valid && pixel_ready;
         @(posedge Clock); #1;
         guard++;
         if (!sent && guard > 1000) begin
            check_val("pixel_accept_timeout", 0, 1);
            sent = 1;
         end
      end
      pixel_valid = 1'b0;
   endtask

   task automatic send_pairs(input logic [17:0] base, input int k0, input int n, input int pct);
      logic [23:0] p0, p1;
      for (int i = 0; i < n; i++) begin
         p0 = 24'($urandom);
         p1 = 24'($urandom);
         model_pair(base, k0 + i, p0, p1);
         send_pixel(p0, pct);
         send_pixel(p1, pct);
      end
   endtask

   task automatic wait_done(output int c_d);
      int guard = 0;
      c_d = -1;
      while (done !== 1'b1 && guard < 2000) begin
         @(negedge Clock);
         guard++;
      end
      check_val("done_seen", done, 1);
      c_d = cyc;
      @(posedge Clock); #1;
      frames_exp++;
      check_val("done_count", 34'(done_cnt), 34'(frames_exp));
      check_val("done_cleared", done, 0);
      check_val("idle_after_done", busy, 0);
   endtask

   task automatic compare_frame(input string tag);
      int n;
      check_val({tag, "_nwords"}, 34'(got_q.size()), 34'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         if (got_q[i] !== exp_q[i])
            check_val({tag, "_word"}, got_q[i], exp_q[i]);
         else
            n_checks++;
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int c_s, c_d;
      logic [17:0] b;
      Reset = 1'b1;
      start = 1'b0;
      SRAM_base_address = '0;
      pixel_valid = 1'b0;
      {pixel_R, pixel_G, pixel_B} = '0;

      // reset state
      repeat (3) @(posedge Clock);
      #1;
      check_val("rst_we_n", SRAM_we_n, 1);
      check_val("rst_addr", SRAM_address, 0);
      check_val("rst_data", SRAM_write_data, 0);
      check_val("rst_ready", pixel_ready, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      Reset = 1'b0;
      got_q.delete();

      // fixed first pair at the display base, exact write timing
      b = RGB_BASE_ADDRESS;
      start_frame(b, c_s);
      model_pair(b, 0, 24'h112233, 24'h445566);
      send_pixel(24'h112233, 100);
      send_pixel(24'h445566, 100);
      check_val("t1_we0", SRAM_we_n, 0);
      check_val("t1_w0", {SRAM_address, SRAM_write_data}, {18'd146944, 16'h1122});
      check_val("t1_ready_wr", pixel_ready, 0);
      @(posedge Clock); #1;
      check_val("t1_we1", SRAM_we_n, 0);
      check_val("t1_w1", {SRAM_address, SRAM_write_data}, {18'd146945, 16'h3344});
      @(posedge Clock); #1;
      check_val("t1_we2", SRAM_we_n, 0);
      check_val("t1_w2", {SRAM_address, SRAM_write_data}, {18'd146946, 16'h5566});
      @(posedge Clock); #1;
      check_val("t1_we_off", SRAM_we_n, 1);
      check_val("t1_hold_addr", SRAM_address, 18'd146946);
      send_pairs(b, 1, NPAIR - 1, 100);
      wait_done(c_d);
      compare_frame("t1");

      // random valid gaps
      b = 18'($urandom_range(200000));
      start_frame(b, c_s);
      send_pairs(b, 0, NPAIR, 50);
      wait_done(c_d);
      compare_frame("t2");

      // full frame, no stalls: cycle count, then restart at another base
      b = 18'($urandom_range(100000));
      start_frame(b, c_s);
      send_pairs(b, 0, NPAIR, 100);
      wait_done(c_d);
      check_val("t3_cycles", 34'(c_d - c_s + 1), 34'(5 * NPAIR + 2));
      compare_frame("t3");
      b = b + 18'd1000;
      start_frame(b, c_s);
      send_pairs(b, 0, NPAIR, 80);
      wait_done(c_d);
      compare_frame("t3b");

      // start mid-frame is ignored
      b = 18'd5000;
      start_frame(b, c_s);
      send_pairs(b, 0, 3, 100);
      start = 1'b1;
      SRAM_base_address = 18'd90000;
      @(posedge Clock); #1;
      start = 1'b0;
      check_val("t4_still_busy", busy, 1);
      send_pairs(b, 3, NPAIR - 3, 70);
      wait_done(c_d);
      compare_frame("t4");

      // reset during the second write of pair 1
      b = 18'd7000;
      start_frame(b, c_s);
      send_pairs(b, 0, 2, 100);
      @(posedge Clock); #1;
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      check_val("t5_we_n", SRAM_we_n, 1);
      check_val("t5_addr", SRAM_address, 0);
      check_val("t5_busy", busy, 0);
      check_val("t5_ready", pixel_ready, 0);
      repeat (6) @(posedge Clock);
      #1;
      check_val("t5_writes_before_abort", 34'(got_q.size()), 34'd5);
      check_val("t5_no_done", 34'(done_cnt), 34'(frames_exp));
      got_q.delete();
      exp_q.delete();
      b = 18'($urandom);
      start_frame(b, c_s);
      send_pairs(b, 0, NPAIR, 60);
      wait_done(c_d);
      compare_frame("t5_restart");

      // address wrap past 2^18-1
      b = 18'd262142;
      start_frame(b, c_s);
      send_pairs(b, 0, NPAIR, 90);
      wait_done(c_d);
      if (got_q.size() >= 3) begin
         check_val("t6_a0", got_q[0][33:16], 18'd262142);
         check_val("t6_a1", got_q[1][33:16], 18'd262143);
         check_val("t6_a2", got_q[2][33:16], 18'd0);
      end else begin
         check_val("t6_enough_words", 34'(got_q.size()), 34'(NWORD));
      end
      compare_frame("t6");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
